div_unit: RTL and testbench

//  Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage.

---
 rtl/div_unit.sv | 148 ++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage
module div_unit #(
    parameter logic [7:0] DIV_OP  = 8'h1A,
    parameter logic [7:0] DIVU_OP = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        stallE,
    input  logic        flushE,
    output logic        stall_div,
    output logic        div_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_div;
    logic        sgn;
    logic [31:0] a_abs;
    logic [31:0] b_abs_in;

    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] b_abs;
    logic        q_neg;
    logic        r_neg;

    logic [33:0] shifted;
    logic [33:0] trial;
    logic        borrow;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] lo_final;
    logic [31:0] hi_final;

    assign is_div    = (alucontrolE == DIV_OP) | (alucontrolE == DIVU_OP);
    assign sgn       = (alucontrolE == DIV_OP);
    assign stall_div = is_div & (state != DONE) & ~flushE;
    assign div_valid = (state == DONE);

    // Operand magnitudes; only a signed divide takes the absolute value
    always_comb begin
        a_abs    = (sgn & srcaE[31]) ? (32'd0 - srcaE) : srcaE;
        b_abs_in = (sgn & srcbE[31]) ? (32'd0 - srcbE) : srcbE;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract |b|, keep difference when no borrow
    always_comb begin
        shifted  = {rem, quo[31]};
        trial    = shifted - {2'b00, b_abs};
        borrow   = trial[33];
        rem_step = borrow ? shifted[32:0] : trial[32:0];
        quo_step = {quo[30:0], ~borrow};
        lo_final = q_neg ? (32'd0 - quo_step) : quo_step;
        hi_final = r_neg ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush cancels whatever is in progress
    always_comb begin
        state_next = state;
        if (flushE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        state_next = (srcbE == 32'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 5'd31) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (!stallE) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: latch operands on issue, iterate while busy, publish the signed result on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 5'd0;
            rem   <= 33'd0;
            quo   <= 32'd0;
            b_abs <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi_o  <= 32'd0;
            lo_o  <= 32'd0;
        end else if (!flushE) begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        if (srcbE != 32'd0) begin
                            cnt   <= 5'd0;
                            rem   <= 33'd0;
                            quo   <= a_abs;
                            b_abs <= b_abs_in;
                            q_neg <= (srcaE[31] ^ srcbE[31]) & sgn;
                            r_neg <= srcaE[31] & sgn;
                        end else begin
                            lo_o <= 32'hFFFF_FFFF;
                            hi_o <= srcaE;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        lo_o <= lo_final;
                        hi_o <= hi_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    localparam logic [7:0] DIV_OP  = 8'h1A;
    localparam logic [7:0] DIVU_OP = 8'h1B;

    logic        clk;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic        flushE;
    logic        stall_div;
    logic        div_valid;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alucontrolE(alucontrolE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .stallE     (stallE),
        .flushE     (flushE),
        .stall_div  (stall_div),
        .div_valid  (div_valid),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a divide and count cycles with stall_div high; operands are scrambled after issue
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cycles);
        @(negedge clk);
        alucontrolE = op;
        srcaE = a;
        srcbE = b;
        #1;
        cycles = 0;
        while (stall_div === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
            if (cycles == 1) begin
                srcaE = 32'hDEAD_BEEF;
                srcbE = 32'h0000_0003;
            end
        end
    endtask

    task automatic check_result(input string name, input int cycles, input int exp_cycles,
                                input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        checks++;
        if (cycles != exp_cycles) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d expected %0d", name, cycles, exp_cycles);
        end
        checks++;
        if (div_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s div_valid got %b expected 1", name, div_valid);
        end
        checks++;
        if (lo_o !== exp_lo) begin
            errors++;
            $display("FAIL %s lo got %h expected %h", name, lo_o, exp_lo);
        end
        checks++;
        if (hi_o !== exp_hi) begin
            errors++;
            $display("FAIL %s hi got %h expected %h", name, hi_o, exp_hi);
        end
    endtask

    task automatic retire(input string name);
        @(negedge clk);
        alucontrolE = 8'h00;
        srcaE = 32'd0;
        srcbE = 32'd0;
        #1;
        checks++;
        if (div_valid !== 1'b0 || stall_div !== 1'b0) begin
            errors++;
            $display("FAIL %s retire valid/stall got %b%b expected 00", name, div_valid, stall_div);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        alucontrolE = DIV_OP;
        srcaE = 32'd10;
        srcbE = 32'd3;
        stallE = 1'b0;
        flushE = 1'b0;
        #2;
        checks++;
        if (stall_div !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_eq got %b expected 1", stall_div);
        end
        alucontrolE = 8'h00;
        #1;
        checks++;
        if (stall_div !== 1'b0 || div_valid !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b valid=%b hi=%h lo=%h expected 0", stall_div,
                     div_valid, hi_o, lo_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu();
        int c;
        run_div(DIVU_OP, 32'd100, 32'd7, c);
        check_result("divu_100_7", c, 33, 32'd14, 32'd2);
        retire("divu_100_7");
    endtask

    task automatic test_signed();
        int c;
        run_div(DIV_OP, 32'hFFFF_FFF9, 32'd2, c);
        check_result("div_m7_2", c, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        retire("div_m7_2");
        run_div(DIV_OP, 32'd7, 32'hFFFF_FFFE, c);
        check_result("div_7_m2", c, 33, 32'hFFFF_FFFD, 32'd1);
        retire("div_7_m2");
    endtask

    task automatic test_div_zero();
        int c;
        run_div(DIV_OP, 32'd5, 32'd0, c);
        check_result("div_5_0", c, 1, 32'hFFFF_FFFF, 32'd5);
        retire("div_5_0");
    endtask

    task automatic test_flush();
        int rises;
        @(negedge clk);
        alucontrolE = DIVU_OP;
        srcaE = 32'd50;
        srcbE = 32'd3;
        #1;
        checks++;
        if (stall_div !== 1'b1) begin
            errors++;
            $display("FAIL flush_issue_stall got %b expected 1", stall_div);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        flushE = 1'b1;
        #1;
        checks++;
        if (stall_div !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got %b expected 0", stall_div);
        end
        @(negedge clk);
        flushE = 1'b0;
        alucontrolE = 8'h00;
        #1;
        checks++;
        if (stall_div !== 1'b0 || div_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got stall=%b valid=%b expected 0 0", stall_div, div_valid);
        end
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_valid !== 1'b0) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL flush_no_valid got %0d valid cycles expected 0", rises);
        end
        checks++;
        if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'd5) begin
            errors++;
            $display("FAIL flush_keep got lo=%h hi=%h expected ffffffff 00000005", lo_o, hi_o);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        run_div(DIVU_OP, 32'd1000, 32'd13, c);
        check_result("hold_1000_13", c, 33, 32'd76, 32'd12);
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (div_valid !== 1'b1 || lo_o !== 32'd76 || hi_o !== 32'd12 || stall_div !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%b stall=%b lo=%h hi=%h expected 1 0 4c c", i,
                         div_valid, stall_div, lo_o, hi_o);
            end
            @(negedge clk);
            #1;
        end
        stallE = 1'b0;
        checks++;
        if (div_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got valid=%b expected 1", div_valid);
        end
        run_div(DIVU_OP, 32'd9, 32'd3, c);
        check_result("divu_9_3", c, 33, 32'd3, 32'd0);
        retire("divu_9_3");
    endtask

    task automatic test_reset_mid_busy();
        int c;
        @(negedge clk);
        alucontrolE = DIVU_OP;
        srcaE = 32'd100;
        srcbE = 32'd7;
        for (int i = 0; i < 20; i++) @(negedge clk);
        rst = 1'b0;
        alucontrolE = 8'h00;
        #1;
        checks++;
        if (div_valid !== 1'b0 || stall_div !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b stall=%b hi=%h lo=%h expected all 0", div_valid,
                     stall_div, hi_o, lo_o);
        end
        @(negedge clk);
        rst = 1'b1;
        run_div(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, c);
        check_result("div_overflow", c, 33, 32'h8000_0000, 32'd0);
        retire("div_overflow");
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
